// File: rtl/id_ex_operand_buffer.sv
// Decode-to-execute operand stage: two-entry skid buffer.
// Write-back bypass at capture; held operands snoop the write-back bus.
module id_ex_operand_buffer #(
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              sys_clk,
  input  logic              sys_reset_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       pc_i,
  input  logic [4:0]        RS_addr_i,
  input  logic [4:0]        RT_addr_i,
  input  logic [4:0]        RD_addr_i,
  input  logic [31:0]       RS_data_i,
  input  logic [31:0]       RT_data_i,
  input  logic [31:0]       imm_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [31:0]       wb_data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       pc_o,
  output logic [4:0]        RS_addr_o,
  output logic [4:0]        RT_addr_o,
  output logic [4:0]        RD_addr_o,
  output logic [31:0]       RS_data_o,
  output logic [31:0]       RT_data_o,
  output logic [31:0]       imm_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  typedef struct packed {
    logic [31:0]       pc;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        rd_addr;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [31:0]       imm;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  entry_t     cap;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       head_q;
  logic       head_d;
  logic       tail_q;
  logic       tail_d;
  logic       enq;
  logic       deq;
  logic       wb_live;
  logic [1:0] ent_vld;

  assign in_ready_o  = (count_q < FULL);
  assign out_valid_o = (count_q != 2'd0);

  assign enq = in_valid_i & in_ready_o & ~flush_i;
  assign deq = out_valid_o & out_ready_i & ~flush_i;

  assign wb_live = wb_we_i && (wb_addr_i != 5'd0);

  // x0 always reads zero; otherwise the write-back wins over the regfile
  function automatic logic [31:0] operand(
    input logic [4:0]  addr,
    input logic [31:0] rf
  );
    logic [31:0] v;
    v = rf;
    if (addr == 5'd0) begin
      v = 32'd0;
    end else if (wb_live && wb_addr_i == addr) begin
      v = wb_data_i;
    end
    return v;
  endfunction

  always_comb begin
    cap         = '0;
    cap.pc      = pc_i;
    cap.rs_addr = RS_addr_i;
    cap.rt_addr = RT_addr_i;
    cap.rd_addr = RD_addr_i;
    cap.rs_data = operand(RS_addr_i, RS_data_i);
    cap.rt_data = operand(RT_addr_i, RT_data_i);
    cap.imm     = imm_i;
    cap.ctrl    = ctrl_i;
  end

  always_comb begin
    ent_vld = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ent_vld[i] = (count_q == 2'd2) ||
                   (count_q == 2'd1 && head_q == 1'(i));
    end
  end

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      count_d = 2'd0;
      tail_d  = head_q;
    end else begin
      // held operands track the register file while they wait
      for (int i = 0; i < 2; i++) begin
        if (ent_vld[i] && wb_live) begin
          if (mem_q[i].rs_addr == wb_addr_i) begin
            mem_d[i].rs_data = wb_data_i;
          end
          if (mem_q[i].rt_addr == wb_addr_i) begin
            mem_d[i].rt_data = wb_data_i;
          end
        end
      end
      if (enq) begin
        mem_d[tail_q] = cap;
        tail_d        = ~tail_q;
      end
      if (deq) begin
        head_d = ~head_q;
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      count_q  <= 2'd0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

  assign pc_o      = mem_q[head_q].pc;
  assign RS_addr_o = mem_q[head_q].rs_addr;
  assign RT_addr_o = mem_q[head_q].rt_addr;
  assign RD_addr_o = mem_q[head_q].rd_addr;
  assign RS_data_o = mem_q[head_q].rs_data;
  assign RT_data_o = mem_q[head_q].rt_data;
  assign imm_o     = mem_q[head_q].imm;
  assign ctrl_o    = mem_q[head_q].ctrl;

endmodule

// File: tb/tb_id_ex_operand_buffer.sv
// Scoreboard bench for id_ex_operand_buffer.
// A queue model predicts every head entry and the handshake flags.
module tb_id_ex_operand_buffer;

  localparam int CW = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [CW-1:0] ctrl;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   pc = '0;
  logic [4:0]    rs_a = '0;
  logic [4:0]    rt_a = '0;
  logic [4:0]    rd_a = '0;
  logic [31:0]   rs_d = '0;
  logic [31:0]   rt_d = '0;
  logic [31:0]   imm = '0;
  logic [CW-1:0] ctrl = '0;
  logic          wb_we = 1'b0;
  logic [4:0]    wb_a = '0;
  logic [31:0]   wb_d = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   pc_o;
  logic [4:0]    rs_ao;
  logic [4:0]    rt_ao;
  logic [4:0]    rd_ao;
  logic [31:0]   rs_do;
  logic [31:0]   rt_do;
  logic [31:0]   imm_o;
  logic [CW-1:0] ctrl_o;

  int total = 0;
  int bad = 0;
  ent_t model[$];

  id_ex_operand_buffer #(.CTRL_W(CW), .DEPTH(2)) dut (
    .sys_clk(clk), .sys_reset_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pc_i(pc), .RS_addr_i(rs_a), .RT_addr_i(rt_a),
    .RD_addr_i(rd_a), .RS_data_i(rs_d), .RT_data_i(rt_d),
    .imm_i(imm), .ctrl_i(ctrl),
    .wb_we_i(wb_we), .wb_addr_i(wb_a), .wb_data_i(wb_d),
    .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pc_o(pc_o), .RS_addr_o(rs_ao), .RT_addr_o(rt_ao),
    .RD_addr_o(rd_ao), .RS_data_o(rs_do), .RT_data_o(rt_do),
    .imm_o(imm_o), .ctrl_o(ctrl_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [159:0] act,
                     input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic ent_t head_out();
    ent_t e;
    e = {pc_o, rs_ao, rt_ao, rd_ao, rs_do, rt_do, imm_o, ctrl_o};
    return e;
  endfunction

  // Reference: read port value as decode would see it after write-back
  function automatic logic [31:0] ref_op(input logic [4:0] a,
                                         input logic [31:0] rf);
    if (a == 0) return 32'd0;
    if (wb_we && wb_a == a) return wb_d;
    return rf;
  endfunction

  // Monitor: mid-cycle, check presented state then advance the model
  always @(negedge clk) begin
    if (rst_n) begin
      int n;
      ent_t e;
      n = model.size();
      chk("in_ready", 160'(in_ready), 160'(n < 2));
      chk("out_valid", 160'(out_valid), 160'(n != 0));
      if (n != 0) chk("head", 160'(head_out()), 160'(model[0]));
      if (flush) begin
        model.delete();
      end else begin
        if (n != 0 && out_ready) void'(model.pop_front());
        if (wb_we && wb_a != 0) begin
          foreach (model[i]) begin
            if (model[i].rs_addr == wb_a) model[i].rs_data = wb_d;
            if (model[i].rt_addr == wb_a) model[i].rt_data = wb_d;
          end
        end
        if (in_valid && n < 2) begin
          e = '{pc, rs_a, rt_a, rd_a, ref_op(rs_a, rs_d),
                ref_op(rt_a, rt_d), imm, ctrl};
          model.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    in_valid = 0; wb_we = 0; flush = 0;
    wb_a = 0; wb_d = 0;
  endtask

  task automatic put(input logic [31:0] p, input logic [4:0] a,
                     input logic [4:0] b, input logic [31:0] da,
                     input logic [31:0] db);
    in_valid = 1; pc = p; rs_a = a; rt_a = b; rd_a = 5'd9;
    rs_d = da; rt_d = db; imm = p ^ 32'h5a5a; ctrl = p[15:0];
  endtask

  task automatic drain();
    quiet();
    out_ready = 1;
    repeat (3) tick();
  endtask

  initial begin
    bit acc;
    int k;
    #2;
    chk("rst_valid", 160'(out_valid), 160'(0));
    chk("rst_ready", 160'(in_ready), 160'(1));
    chk("rst_data", 160'(head_out()), 160'(0));
    tick();
    rst_n = 1;

    // single instruction
    out_ready = 1;
    put(32'h40, 5'd3, 5'd4, 32'h11, 32'h22);
    tick();
    quiet();
    chk("t1_valid", 160'(out_valid), 160'(1));
    chk("t1_rs", 160'(rs_do), 160'(32'h11));
    chk("t1_rt", 160'(rt_do), 160'(32'h22));
    chk("t1_ready", 160'(in_ready), 160'(1));
    drain();

    // capture bypass, then x0 with the same write-back
    put(32'h50, 5'd5, 5'd6, 32'h0, 32'h66);
    wb_we = 1; wb_a = 5'd5; wb_d = 32'hdeadbeef;
    tick();
    quiet();
    chk("byp_rs", 160'(rs_do), 160'(32'hdeadbeef));
    drain();
    put(32'h54, 5'd0, 5'd6, 32'h123, 32'h66);
    wb_we = 1; wb_a = 5'd0; wb_d = 32'hdeadbeef;
    tick();
    quiet();
    chk("byp_x0", 160'(rs_do), 160'(0));
    drain();

    // backpressure
    out_ready = 0;
    put(32'h100, 5'd1, 5'd2, 32'h1, 32'h2);
    tick();
    put(32'h104, 5'd1, 5'd2, 32'h3, 32'h4);
    tick();
    chk("bp_full", 160'(in_ready), 160'(0));
    put(32'h108, 5'd1, 5'd2, 32'h5, 32'h6);
    tick();
    chk("bp_hold", 160'(pc_o), 160'(32'h100));
    out_ready = 1;
    k = 0;
    do begin
      acc = in_ready;
      tick();
      k++;
    end while (!acc && k < 10);
    chk("bp_accept", 160'(acc), 160'(1));
    drain();

    // snoop while stalled
    out_ready = 0;
    put(32'h200, 5'd0, 5'd7, 32'h77, 32'h1);
    tick();
    quiet();
    chk("sn_pre", 160'(rt_do), 160'(1));
    wb_we = 1; wb_a = 5'd7; wb_d = 32'h55;
    tick();
    chk("sn_rt", 160'(rt_do), 160'(32'h55));
    wb_a = 5'd0; wb_d = 32'h99;
    tick();
    quiet();
    chk("sn_x0", 160'(rs_do), 160'(0));
    drain();

    // flush with full buffer
    out_ready = 0;
    put(32'h300, 5'd1, 5'd2, 32'h1, 32'h2);
    tick();
    put(32'h304, 5'd1, 5'd2, 32'h1, 32'h2);
    tick();
    put(32'hbad0, 5'd1, 5'd2, 32'h1, 32'h2);
    flush = 1;
    out_ready = 1;
    tick();
    quiet();
    chk("fl_valid", 160'(out_valid), 160'(0));
    chk("fl_ready", 160'(in_ready), 160'(1));
    drain();

    // asynchronous reset mid-operation
    out_ready = 0;
    put(32'h400, 5'd1, 5'd2, 32'h1, 32'h2);
    tick();
    put(32'h404, 5'd1, 5'd2, 32'h1, 32'h2);
    tick();
    quiet();
    #1;
    rst_n = 0;
    model.delete();
    #1;
    chk("ar_valid", 160'(out_valid), 160'(0));
    chk("ar_data", 160'(head_out()), 160'(0));
    chk("ar_ready", 160'(in_ready), 160'(1));
    tick();
    rst_n = 1;
    out_ready = 1;
    put(32'h500, 5'd8, 5'd9, 32'h88, 32'h99);
    tick();
    quiet();
    chk("ar_after", 160'(pc_o), 160'(32'h500));
    drain();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      pc        = $urandom;
      rs_a      = 5'($urandom_range(0, 7));
      rt_a      = 5'($urandom_range(0, 7));
      rd_a      = 5'($urandom);
      rs_d      = $urandom;
      rt_d      = $urandom;
      imm       = $urandom;
      ctrl      = CW'($urandom);
      wb_we     = $urandom_range(0, 1) == 1;
      wb_a      = 5'($urandom_range(0, 7));
      wb_d      = $urandom;
      flush     = $urandom_range(0, 15) == 0;
      out_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_buffer.md
Name: id_ex_operand_buffer

Overview:
- Decode-to-execute operand stage of the RISC-V core. It sits directly downstream of the 32x32 register file.
- Captures the two combinational read ports (rs/rt data) together with the decoded instruction fields, and applies write-back bypass at capture time.
- Holds up to two instructions in a skid buffer with valid/ready handshakes so the execute stage can stall without a combinational ready path back to decode.
- While an instruction waits in the buffer, it snoops the write-back bus so that its held operands never go stale.

Parameters:
- CTRL_W, 16: width of the opaque decoded control bundle carried alongside the operands.
- DEPTH, 2: buffer entries. Only 2 is supported; the count is 2 bits.

Ports:
- sys_clk  in  1  core clock; all state updates on its rising edge.
- sys_reset_n  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  decode presents an instruction.
- in_ready_o  out  1  buffer can accept; equals (count < 2), derived from registered count only.
- pc_i  in  32  instruction PC.
- RS_addr_i  in  5  source 1 index; also drives the register file RS read port.
- RT_addr_i  in  5  source 2 index; also drives the register file RT read port.
- RD_addr_i  in  5  destination index.
- RS_data_i  in  32  register file RS read data (combinational).
- RT_data_i  in  32  register file RT read data (combinational).
- imm_i  in  32  sign-extended immediate.
- ctrl_i  in  CTRL_W  decoded control bundle.
- wb_we_i  in  1  write-back enable; same bus that drives the register file write port.
- wb_addr_i  in  5  write-back destination.
- wb_data_i  in  32  write-back data.
- flush_i  in  1  discard all buffered and incoming instructions (branch/jump redirect).
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  execute stage accepts the head entry.
- pc_o  out  32  head entry PC.
- RS_addr_o  out  5  head entry source 1 index.
- RT_addr_o  out  5  head entry source 2 index.
- RD_addr_o  out  5  head entry destination index.
- RS_data_o  out  32  head entry operand 1.
- RT_data_o  out  32  head entry operand 2.
- imm_o  out  32  head entry immediate.
- ctrl_o  out  CTRL_W  head entry control bundle.

Behaviour:
- Reset: async assertion clears count, head/tail pointers and all entry fields to 0.
  - out_valid_o=0; all data outputs 0; in_ready_o=1.
  - Deassertion is followed by a normal first edge.
- Enqueue: occurs when in_valid_i & in_ready_o & !flush_i. Captured operand = wb_data_i if (wb_we_i && wb_addr_i!=0 && wb_addr_i==RS_addr_i), else RS_data_i; RT identically.
- x0 rule: an operand whose address is 0 is captured and held as 0, regardless of RS/RT_data_i and regardless of any write-back.
- Dequeue: occurs when out_valid_o & out_ready_i & !flush_i.
- Latency: an entry enqueued at edge N is visible at the outputs from edge N (out_valid_o high in cycle N+1) if the buffer was empty. There is no combinational path from any in_* signal to any out_* signal.
- FIFO order is strict. Outputs are driven from the head entry; out_valid_o = (count != 0).
- count transitions:
  - enq only: +1.
  - deq only: −1.
  - enq and deq in the same cycle: unchanged (possible only at count=1).
  - count=2: in_ready_o=0, so no enqueue occurs.
- Snoop: every edge with wb_we_i && wb_addr_i!=0, each valid entry whose RS_addr (or RT_addr) equals wb_addr_i has that operand replaced with wb_data_i.
  - This applies in the same cycle as that entry's dequeue; the value already presented on the outputs that cycle is the one consumed.
  - It also applies to an entry being enqueued that cycle, which is equivalent to the capture bypass.
- Flush: flush_i at an edge sets count=0 and invalidates all entries. Any enqueue or dequeue in that cycle is dropped. out_valid_o=0 in the following cycle.
  - Flush has priority over enqueue, dequeue and snoop.
  - Entry data need not be cleared, but out_valid_o must be 0.
- Pointers wrap modulo 2.
- Inputs presented while in_ready_o=0 are ignored; decode holds them.
- Handshake rule: once out_valid_o is asserted, the head fields stay stable until dequeue or flush; snoop updates are the only permitted change.

Test Plan:
- Reset then a single instruction (RS=3, RT=4, regfile returns 0x11/0x22, out_ready_i=1) -> out_valid_o=1 one cycle later with RS_data_o=0x11, RT_data_o=0x22; in_ready_o stays 1.
- Capture bypass: enqueue with RS_addr=5 while wb_we_i=1, wb_addr_i=5, wb_data_i=0xDEADBEEF, RS_data_i=0 -> RS_data_o=0xDEADBEEF. Repeat with addresses 0 -> RS_data_o=0.
- Backpressure: out_ready_i=0, enqueue 3 back-to-back (PC 0x100, 0x104, 0x108) -> in_ready_o drops after the 2nd; release out_ready_i -> PCs emerge 0x100, 0x104, and 0x108 is accepted only after in_ready_o returns.
- Snoop while stalled: entry RT=7 holding 0x1 stalled; write-back 7<-0x55 -> RT_data_o becomes 0x55 next cycle. A write-back to x0 with wb_data 0x99 leaves an x0 operand at 0.
- Flush: count=2, flush_i=1 together with in_valid_i=1 and out_ready_i=1 -> next cycle out_valid_o=0, in_ready_o=1; the flushed PC never appears.
- Reset mid-operation: assert sys_reset_n=0 asynchronously with count=2 -> out_valid_o=0 and outputs 0 immediately without a clock edge; after release, normal enqueue works.
